ps2_host_tx: RTL
================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 800, clk cycles ps2_clk_oe is held before the start bit (100 us at 8 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 16000, max clk cycles between device clock falling edges before abort.
REQ-003 clk  in  1  system clock; all logic on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 data_in  in  8  command byte from CPU bus.
REQ-006 addr  in  1  register select: 0 = tx byte, 1 = status.
REQ-007 wr  in  1  write strobe, one clk cycle per access.
REQ-008 data_out  out  8  addr=0: last accepted byte; addr=1: {5'b0, err, busy, done}.
REQ-009 tx_int  out  1  one-cycle completion pulse.
REQ-010 ps2_clk_in, ps2_data_in  in  1 each  raw PS/2 line levels, asynchronous.
REQ-011 ps2_clk_oe, ps2_data_oe  out  1 each  1 = pull line low (open drain), 0 = release.

Function
REQ-012 wr with addr=0 while busy=0 shall latch data_in, clear done/err, set busy, enter INHIBIT next cycle; otherwise the write is ignored.
REQ-013 wr with addr=1 shall have no effect.
REQ-014 Lines shall pass through a 2-FF synchronizer; a falling edge of ps2_clk shall be flagged 3 clk cycles after the pin edge at most.
REQ-015 States: IDLE, INHIBIT, REQ, DATA, PARITY, STOP, ACK, WAIT_IDLE.
REQ-016 INHIBIT: ps2_clk_oe=1 for INHIBIT_CYCLES, then ps2_data_oe=1 and go to REQ next cycle.
REQ-017 REQ: ps2_clk_oe=0, ps2_data_oe=1; first falling edge -> drive bit0, go DATA.
REQ-018 DATA: each falling edge drives the next bit LSB first (ps2_data_oe = ~bit); after bit7 the next edge drives odd parity (XNOR of all 8 bits) and enters PARITY.
REQ-019 PARITY: next falling edge releases ps2_data_oe (stop bit), go STOP.
REQ-020 STOP: next falling edge samples synchronized data; 0 = ack ok, 1 sets err; go WAIT_IDLE.
REQ-021 WAIT_IDLE: once both synchronized lines are 1, clear busy, set done, pulse tx_int one cycle, go IDLE.
REQ-022 ps2_data_oe shall update within 1 clk cycle of the edge flag; device edges in IDLE and INHIBIT shall be ignored.
REQ-023 done and err persist until the next accepted write or reset.
REQ-024 A wr coinciding with the completion cycle shall be ignored (busy still 1).

Reset
REQ-025 Reset in any state, including mid-frame: state IDLE, both oe=0, busy/done/err=0, tx_int=0, latched byte 0x00, counters 0, on the next clk edge.

Configuration
REQ-026 With PS2_TX_TIMEOUT_EN defined: in REQ through STOP, TIMEOUT_CYCLES without a falling edge releases both lines, sets err and done, clears busy, pulses tx_int, returns to IDLE.
REQ-027 Without PS2_TX_TIMEOUT_EN: no watchdog counter; the FSM waits indefinitely for device edges.

Structure
REQ-028 Package ps2_pkg shall hold the state encoding and status bit positions, shared with the receiver.
REQ-029 Sub-module ps2_sync_edge: 2-FF synchronizer plus falling-edge detect, instantiated for ps2_clk and ps2_data.

Verification
REQ-030 Write 0x07, device model clocks 11 edges, acks low -> line bits 1,1,1,0,0,0,0,0, parity 0, stop 1; status 0x01; one tx_int pulse.
REQ-031 Write 0xED -> parity bit 1; ps2_clk_oe low exactly INHIBIT_CYCLES cycles before ps2_data_oe asserts.
REQ-032 Device leaves data high at ack edge -> status 0x05 (err, done), tx_int pulse.
REQ-033 Write 0x55 while busy -> ignored; byte 0x07 still sent, data_out(addr=0)=0x07.
REQ-034 Reset asserted after 4th data bit -> both oe=0 next cycle, status 0x00, no tx_int.
REQ-035 PS2_TX_TIMEOUT_EN defined, device stops after 3 edges -> after TIMEOUT_CYCLES lines released, status 0x05, tx_int pulse; undefined -> busy stays 1.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, status register layout, parity helper.
package ps2_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned STAT_DONE = 0;
    localparam int unsigned STAT_BUSY = 1;
    localparam int unsigned STAT_ERR  = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_DATA      = 3'd3,
        ST_PARITY    = 3'd4,
        ST_STOP      = 3'd5,
        ST_ACK       = 3'd6,
        ST_WAIT_IDLE = 3'd7
    } ps2_state_e;

    // Odd parity bit: makes the total count of ones (data + parity) odd.
    function automatic logic odd_parity(input logic [DATA_W-1:0] b);
        return ~(^b);
    endfunction

    // Status register image {5'b0, err, busy, done}.
    function automatic logic [DATA_W-1:0] pack_status(input logic err,
                                                      input logic busy,
                                                      input logic done);
        logic [DATA_W-1:0] s;
        s            = '0;
        s[STAT_ERR]  = err;
        s[STAT_BUSY] = busy;
        s[STAT_DONE] = done;
        return s;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one PS/2 line with a registered falling-edge flag.
module ps2_sync_edge #(
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic fall
);

    logic meta;

    // Synchronize the pin; flag a high-to-low transition as it leaves the second stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta  <= RESET_LEVEL;
            level <= RESET_LEVEL;
            fall  <= 1'b0;
        end else begin
            meta  <= pin;
            level <= meta;
            fall  <= level & ~meta;
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter with a CPU register interface.
// Optional watchdog: define PS2_TX_TIMEOUT_EN to abort a frame when the device
// stops clocking for TIMEOUT_CYCLES.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 800,
    parameter int unsigned TIMEOUT_CYCLES = 16000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              addr,
    input  logic              wr,
    output logic [DATA_W-1:0] data_out,
    output logic              tx_int,
    input  logic              ps2_clk_in,
    input  logic              ps2_data_in,
    output logic              ps2_clk_oe,
    output logic              ps2_data_oe
);

    localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam int unsigned BIT_W = 4;
    localparam logic [BIT_W-1:0] PARITY_SLOT = BIT_W'(DATA_W);

    ps2_state_e        state_q, state_d;
    logic [INH_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] tx_byte_q, tx_byte_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              tx_int_d;
    logic              clk_oe_d, data_oe_d;
    logic [DATA_W-1:0] data_out_d;

    logic clk_level, clk_fall;
    logic data_level, data_fall;
    logic unused_data_fall;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] wd_q, wd_d;
`endif

    ps2_sync_edge u_sync_clk (
        .clk   (clk),
        .reset (reset),
        .pin   (ps2_clk_in),
        .level (clk_level),
        .fall  (clk_fall)
    );

    ps2_sync_edge u_sync_data (
        .clk   (clk),
        .reset (reset),
        .pin   (ps2_data_in),
        .level (data_level),
        .fall  (data_fall)
    );

    // Data-line falling edges carry no meaning for the transmitter.
    assign unused_data_fall = data_fall;

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            tx_byte_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            tx_int      <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            data_out    <= '0;
`ifdef PS2_TX_TIMEOUT_EN
            wd_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_byte_q   <= tx_byte_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            tx_int      <= tx_int_d;
            ps2_clk_oe  <= clk_oe_d;
            ps2_data_oe <= data_oe_d;
            data_out    <= data_out_d;
`ifdef PS2_TX_TIMEOUT_EN
            wd_q        <= wd_d;
`endif
        end
    end

    // Next-state and output logic for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_byte_d  = tx_byte_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        tx_int_d   = 1'b0;
        clk_oe_d   = ps2_clk_oe;
        data_oe_d  = ps2_data_oe;
`ifdef PS2_TX_TIMEOUT_EN
        wd_d       = '0;
`endif

        case (state_q)
            ST_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (wr && !addr && !busy_q) begin
                    tx_byte_d = data_in;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    clk_oe_d  = 1'b1;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                clk_oe_d = 1'b1;
                if (cnt_q == INH_LAST) begin
                    cnt_d     = '0;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    state_d   = ST_REQ;
                end else begin
                    cnt_d = cnt_q + INH_W'(1);
                end
            end
            ST_REQ: begin
                clk_oe_d = 1'b0;
                if (clk_fall) begin
                    data_oe_d = ~tx_byte_q[0];
                    bit_cnt_d = BIT_W'(1);
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (clk_fall) begin
                    if (bit_cnt_q == PARITY_SLOT) begin
                        data_oe_d = ~odd_parity(tx_byte_q);
                        state_d   = ST_PARITY;
                    end else begin
                        data_oe_d = ~tx_byte_q[bit_cnt_q[2:0]];
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (clk_fall) begin
                    data_oe_d = 1'b0;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (clk_fall) begin
                    err_d   = data_level;
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_level && data_level) begin
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    tx_int_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        // Watchdog: abort the frame if the device stops clocking.
        if (state_q inside {ST_REQ, ST_DATA, ST_PARITY, ST_STOP}) begin
            if (clk_fall) begin
                wd_d = '0;
            end else if (wd_q == TO_LAST) begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                err_d     = 1'b1;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                tx_int_d  = 1'b1;
                state_d   = ST_IDLE;
            end else begin
                wd_d = wd_q + TO_W'(1);
            end
        end
`endif

        data_out_d = addr ? pack_status(err_d, busy_d, done_d) : tx_byte_d;
    end

endmodule
